// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding,
// default frame geometry and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam int UART_DEF_OVERSAMPLE = 16;
    localparam int UART_DEF_DATA_BITS  = 8;
    localparam int UART_MAX_DATA_BITS  = 9;

    // Narrower payloads are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(
        input logic [UART_MAX_DATA_BITS-1:0] data,
        input logic                          odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Parametrised UART serializer: start, DATA_BITS LSB-first,
// optional parity, 1 or 2 stop bits, OVERSAMPLE br_ticks per bit.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DEF_DATA_BITS,
    parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic ODD = (PARITY_ODD != 0);

    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        (PARITY_EN != 0 && PARITY_EN != 1) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1) ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_tx_cfg: illegal parameter combination");
    end

    uart_tx_state_e state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic par_q, par_d;
    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic tick_end;
    logic [UART_MAX_DATA_BITS-1:0] data_ext;

    always_comb begin
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = tx_data;
    end

    assign tick_end = br_tick && (tick_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // A tick on the acceptance edge is deliberately not counted.
        if (state_q != IDLE && br_tick) begin
            tick_d = tick_end ? '0 : tick_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d = tx_data;
                    par_d   = calc_parity(data_ext, ODD);
                    busy_d  = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    tick_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                if (tick_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick_end) begin
                    if (STOP_BITS == 1 || stop_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: three configurations,
// line sampled once per br_tick and compared to a frame model.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       tick  [3];
    logic       start [3];
    logic [8:0] data  [3];
    logic       tx_w  [3];
    logic       busy_w[3];
    logic       done_w[3];

    int checks = 0;
    int errors = 0;

    int db_c[3] = '{8, 7, 7};
    int os_c[3] = '{16, 4, 4};
    int pe_c[3] = '{0, 1, 1};
    int po_c[3] = '{0, 0, 1};
    int sb_c[3] = '{1, 2, 2};

    logic [15:0] expq[3][$];
    bit          mact [3];
    int          mcnt [3];
    int          merr [3];
    int          mbadi[3];
    logic        mbadv[3];
    logic [15:0] mexp [3];
    bit          pdone[3];
    int          ndone[3];
    int          nexp [3];
    int          c1 = 0;
    int          c2 = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .br_tick(tick[0]), .tx_start(start[0]),
        .tx_data(data[0][7:0]), .tx_busy(busy_w[0]),
        .tx_done(done_w[0]), .tx(tx_w[0]));

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(2)) u_d1 (
        .clk(clk), .rst(rst), .br_tick(tick[1]), .tx_start(start[1]),
        .tx_data(data[1][6:0]), .tx_busy(busy_w[1]),
        .tx_done(done_w[1]), .tx(tx_w[1]));

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_EN(1),
                  .PARITY_ODD(1), .STOP_BITS(2)) u_d2 (
        .clk(clk), .rst(rst), .br_tick(tick[2]), .tx_start(start[2]),
        .tx_data(data[2][6:0]), .tx_busy(busy_w[2]),
        .tx_done(done_w[2]), .tx(tx_w[2]));

    function automatic int nbits(input int i);
        return 1 + db_c[i] + pe_c[i] + sb_c[i];
    endfunction

    // Line bit k of the frame is bit k of the result; stop bits stay 1.
    function automatic logic [15:0] frame_of(input int i, input logic [8:0] d);
        logic [15:0] f;
        logic p;
        f = '1;
        f[0] = 1'b0;
        p = 1'b0;
        for (int k = 0; k < db_c[i]; k++) begin
            f[1+k] = d[k];
            p = p ^ d[k];
        end
        if (pe_c[i] != 0) f[1+db_c[i]] = p ^ (po_c[i] != 0);
        return f;
    endfunction

    // Tick sources: random gaps, every 3 clk, every 7 clk.
    initial begin
        tick = '{default: 1'b0};
        forever begin
            @(posedge clk);
            #1;
            tick[0] = ($urandom_range(0, 2) == 0);
            tick[1] = (c1 == 2);
            tick[2] = (c2 == 6);
            c1 = (c1 + 1) % 3;
            c2 = (c2 + 1) % 7;
        end
    end

    // Monitor: one line sample per br_tick, compared against the queued frame.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    mact[i]  = 1'b0;
                    pdone[i] = 1'b0;
                end else begin
                    if (done_w[i] === 1'b1) ndone[i]++;
                    if (pdone[i]) begin
                        pdone[i] = 1'b0;
                        checks++;
                        if (done_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
                            errors++;
                            $display("FAIL done_end[%0d]: done=%b busy=%b, want done=1 busy=0",
                                     i, done_w[i], busy_w[i]);
                        end
                    end
                    if (tick[i]) begin
                        if (!mact[i] && tx_w[i] === 1'b0) begin
                            mact[i] = 1'b1;
                            mcnt[i] = 0;
                            merr[i] = 0;
                            if (expq[i].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_frame[%0d]: start bit seen, want idle line", i);
                                mexp[i] = '1;
                            end else begin
                                mexp[i] = expq[i].pop_front();
                            end
                        end
                        if (mact[i]) begin
                            if (tx_w[i] !== mexp[i][mcnt[i] / os_c[i]] ||
                                busy_w[i] !== 1'b1) begin
                                if (merr[i] == 0) begin
                                    mbadi[i] = mcnt[i];
                                    mbadv[i] = tx_w[i];
                                end
                                merr[i]++;
                            end
                            mcnt[i]++;
                            if (mcnt[i] == nbits(i) * os_c[i]) begin
                                checks++;
                                if (merr[i] != 0) begin
                                    errors++;
                                    $display("FAIL frame[%0d]: tick %0d line=%b (%0d bad samples), want bits %b LSB-first, busy=1",
                                             i, mbadi[i], mbadv[i], merr[i], mexp[i]);
                                end
                                mact[i]  = 1'b0;
                                pdone[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int i, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[i] !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = (busy_w[i] === 1'b0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout[%0d]: busy=%b, want 0", i, busy_w[i]);
        end
    endtask

    task automatic send(input int i, input logic [8:0] d);
        bit ok;
        wait_idle(i, ok);
        if (!ok) return;
        start[i] = 1'b1;
        data[i]  = d;
        expq[i].push_back(frame_of(i, d));
        nexp[i]++;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        data[i]  = 9'($urandom);
    endtask

    task automatic ignored(input int i);
        int n;
        send(i, 9'h000);
        n = 0;
        while (!(mact[i] && mcnt[i] >= 2 * os_c[i]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        start[i] = 1'b1;
        data[i]  = 9'h1FF;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic b2b(input int i, input logic [8:0] d1, input logic [8:0] d2);
        bit ok;
        int n;
        wait_idle(i, ok);
        if (!ok) return;
        start[i] = 1'b1;
        data[i]  = d1;
        expq[i].push_back(frame_of(i, d1));
        nexp[i]++;
        @(posedge clk);
        #1;
        data[i] = d2;
        expq[i].push_back(frame_of(i, d2));
        nexp[i]++;
        n = 0;
        @(negedge clk);
        while (done_w[i] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_w[i] !== 1'b0 || busy_w[i] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap[%0d]: tx=%b busy=%b one clk after done, want tx=0 busy=1",
                     i, tx_w[i], busy_w[i]);
        end
    endtask

    task automatic run_seq(input int i);
        send(i, (i == 0) ? 9'h0A5 : 9'h043);
        send(i, (i == 0) ? 9'h03C : 9'h02A);
        ignored(i);
        b2b(i, 9'h055, 9'h00F);
        repeat (6) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(i, 9'($urandom));
        end
    endtask

    task automatic reset_test();
        int n;
        int t;
        int bad;
        send(0, 9'h0A5);
        n = 0;
        while (!(mact[0] && mcnt[0] >= 4 * 16 + 8) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: tx=%b busy=%b, want tx=1 busy=0", tx_w[0], busy_w[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t = 0;
        n = 0;
        bad = 0;
        while (t < 500 && n < 5000) begin
            @(negedge clk);
            n++;
            if (tick[0]) t++;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || t < 500) begin
            errors++;
            $display("FAIL idle_after_rst: %0d bad cycles over %0d ticks, want 0 over 500", bad, t);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = '{default: 1'b0};
        data  = '{default: 9'h000};
        for (int i = 0; i < 3; i++) begin
            ndone[i] = 0;
            nexp[i]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: tx=%b busy=%b done=%b, want 1 0 0",
                         i, tx_w[i], busy_w[i], done_w[i]);
            end
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        fork
            run_seq(0);
            run_seq(1);
            run_seq(2);
        join

        n = 0;
        while ((busy_w[0] || busy_w[1] || busy_w[2] || pdone[0] || pdone[1] ||
                pdone[2]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (expq[i].size() != 0 || mact[i]) begin
                errors++;
                $display("FAIL drain[%0d]: %0d frames pending active=%0b, want 0 pending",
                         i, expq[i].size(), mact[i]);
            end
            checks++;
            if (ndone[i] != nexp[i]) begin
                errors++;
                $display("FAIL done_count[%0d]: %0d pulses, want %0d", i, ndone[i], nexp[i]);
            end
        end

        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
